merge_query_arbiter: RTL and testbench

//   Shares one merge_query instance between NUM_REQ upstream requesters (e.g. parallel hash lanes).

---
 rtl/merge_query_arbiter.sv | 120 ++++++++++++
 tb/tb_merge_query_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_query_arbiter.sv
// Shares one merge_query instance between NUM_REQ requester lanes: per-lane 1-entry holds,
// a round-robin forwarder into the queue, and a flush FSM that drains lanes and then the queue.
module merge_query_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int ITEM_LENGTH       = 48,
  parameter int ITEM_COUNTER_SIZE = 12,
  parameter int ID_W              = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*ITEM_LENGTH-1:0]         req_item,
  input  logic [NUM_REQ*(ITEM_COUNTER_SIZE-1)-1:0] req_counter,
  output logic                                   q_valid_in,
  output logic [ITEM_LENGTH-1:0]                 q_item_in,
  output logic [ITEM_COUNTER_SIZE-2:0]           q_counter_in,
  input  logic                                   q_full,
  input  logic                                   q_empty,
  input  logic                                   flush_req,
  output logic                                   flush_done,
  output logic [ID_W-1:0]                        grant_id,
  output logic [15:0]                            drop_cnt,
  output logic [1:0]                             flush_state
);

  localparam int CW = ITEM_COUNTER_SIZE - 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_WAIT_EMPTY, ST_DONE} state_t;

  state_t                 state;
  logic [NUM_REQ-1:0]     hold_vld;
  logic [NUM_REQ-1:0]     hold_vld_nxt;
  logic [NUM_REQ-1:0]     take;
  logic [NUM_REQ-1:0]     zero_take;
  logic [NUM_REQ-1:0]     grant_mask;
  logic [ITEM_LENGTH-1:0] hold_item [NUM_REQ];
  logic [CW-1:0]          hold_cnt  [NUM_REQ];
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        win_id;
  logic [ID_W:0]          cand;
  logic                   win_found;
  logic                   fire;
  logic [4:0]             drop_inc;
  logic [16:0]            drop_sum;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on registered state, never on valid, and valid never waits on ready.
  always_comb begin
    req_ready = '0;
    take      = '0;
    zero_take = '0;
    drop_inc  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n & (state == ST_RUN) & ~hold_vld[i];
      take[i]      = req_valid[i] & req_ready[i] & (req_counter[i*CW +: CW] != '0);
      zero_take[i] = req_valid[i] & req_ready[i] & (req_counter[i*CW +: CW] == '0);
      drop_inc     = drop_inc + {4'b0, zero_take[i]};
    end
    drop_sum = {1'b0, drop_cnt} + {12'b0, drop_inc};
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && hold_vld[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    fire       = win_found & ~q_full & ((state == ST_RUN) | (state == ST_DRAIN));
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_mask[i] = fire & (win_id == ID_W'(i));
    hold_vld_nxt = (hold_vld & ~grant_mask) | take;
    q_valid_in   = fire;
    q_item_in    = fire ? hold_item[win_id] : '0;
    q_counter_in = fire ? hold_cnt[win_id]  : '0;
    grant_id     = fire ? win_id : '0;
    flush_done   = (state == ST_DONE);
    flush_state  = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld <= '0;
      rr_ptr   <= '0;
      state    <= ST_RUN;
      drop_cnt <= '0;
    end else begin
      hold_vld <= hold_vld_nxt;
      if (fire) rr_ptr <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        ST_RUN:        if (flush_req) state <= ST_DRAIN;
        ST_DRAIN:      if (hold_vld_nxt == '0) state <= ST_WAIT_EMPTY;
        ST_WAIT_EMPTY: if (q_empty) state <= ST_DONE;
        default:       state <= ST_RUN;
      endcase
    end
  end

  // Payload registers carry no reset; hold_vld qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (take[i]) begin
        hold_item[i] <= req_item[i*ITEM_LENGTH +: ITEM_LENGTH];
        hold_cnt[i]  <= req_counter[i*CW +: CW];
      end
    end
  end

endmodule

// File: tb/tb_merge_query_arbiter.sv
// Directed bench for merge_query_arbiter: reset, round-robin, backpressure, zero-counter drops,
// flush sequencing, reset during flush and a fairness soak against a counting queue model.
module tb_merge_query_arbiter;

  localparam int N  = 4;
  localparam int IL = 48;
  localparam int CW = 11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IL-1:0] req_item;
  logic [N*CW-1:0] req_counter;
  logic            q_valid_in;
  logic [IL-1:0]   q_item_in;
  logic [CW-1:0]   q_counter_in;
  logic            q_full;
  logic            q_empty;
  logic            flush_req;
  logic            flush_done;
  logic [1:0]      grant_id;
  logic [15:0]     drop_cnt;
  logic [1:0]      flush_state;

  int total = 0;
  int bad   = 0;
  logic [IL-1:0] exp_q[$];

  merge_query_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_item(req_item), .req_counter(req_counter), .q_valid_in(q_valid_in),
    .q_item_in(q_item_in), .q_counter_in(q_counter_in), .q_full(q_full),
    .q_empty(q_empty), .flush_req(flush_req), .flush_done(flush_done),
    .grant_id(grant_id), .drop_cnt(drop_cnt), .flush_state(flush_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [IL-1:0] item, input logic [CW-1:0] cnt);
    req_item[i*IL +: IL]    = item;
    req_counter[i*CW +: CW] = cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_item = '0; req_counter = '0;
    q_full = 1'b0; q_empty = 1'b1; flush_req = 1'b0;
    step(); step();
    total++; if (q_valid_in !== 1'b0) begin bad++; $display("FAIL reset_qvalid got=%0b want=0", q_valid_in); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done got=%0b want=0", flush_done); end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL reset_release_ready got=%b want=1111", req_ready); end
  endtask

  task automatic test_round_robin();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      set_lane(i, IL'(10 + i), CW'(1 + i));
      exp_q.push_back(IL'(10 + i));
    end
    step();
    req_valid = '0;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_ready_held got=%b want=0000", req_ready); end
    for (int k = 0; k < N; k++) begin
      logic [IL-1:0] e;
      e = exp_q.pop_front();
      total++; if (q_valid_in !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0b want=1", k, q_valid_in); end
      total++; if (q_item_in !== e) begin bad++; $display("FAIL rr_item[%0d] got=%0d want=%0d", k, q_item_in, e); end
      total++; if (grant_id !== 2'(k)) begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, grant_id, k); end
      total++; if (q_counter_in !== CW'(k + 1)) begin bad++; $display("FAIL rr_cnt[%0d] got=%0d want=%0d", k, q_counter_in, k + 1); end
      step();
    end
    total++; if (q_valid_in !== 1'b0) begin bad++; $display("FAIL rr_idle got=%0b want=0", q_valid_in); end
    req_valid = 4'b0100;
    set_lane(2, IL'(22), CW'(9));
    step();
    req_valid = '0;
    total++; if (grant_id !== 2'd2 || q_valid_in !== 1'b1) begin bad++; $display("FAIL rr_lane2 got=%0d/%0b want=2/1", grant_id, q_valid_in); end
    total++; if (q_item_in !== IL'(22) || q_counter_in !== CW'(9)) begin bad++; $display("FAIL rr_lane2_data got=%0d/%0d want=22/9", q_item_in, q_counter_in); end
    step();
    total++; if (q_valid_in !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rr_idle_id got=%0b/%0d want=0/0", q_valid_in, grant_id); end
  endtask

  task automatic test_backpressure();
    q_full = 1'b1;
    req_valid = 4'b0011;
    set_lane(0, IL'(30), CW'(2));
    set_lane(1, IL'(31), CW'(3));
    step();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      total++; if (q_valid_in !== 1'b0) begin bad++; $display("FAIL bp_valid[%0d] got=%0b want=0", k, q_valid_in); end
      total++; if (req_ready !== 4'b1100) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=1100", k, req_ready); end
      step();
    end
    q_full = 1'b0;
    #1;
    total++; if (q_valid_in !== 1'b1 || grant_id !== 2'd0 || q_item_in !== IL'(30)) begin bad++; $display("FAIL bp_first got=%0b/%0d/%0d want=1/0/30", q_valid_in, grant_id, q_item_in); end
    step();
    total++; if (q_valid_in !== 1'b1 || grant_id !== 2'd1 || q_item_in !== IL'(31)) begin bad++; $display("FAIL bp_second got=%0b/%0d/%0d want=1/1/31", q_valid_in, grant_id, q_item_in); end
    step();
    total++; if (q_valid_in !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b want=0", q_valid_in); end
  endtask

  task automatic test_zero_counter();
    req_valid = 4'b1000;
    set_lane(3, IL'(7), CW'(0));
    for (int k = 0; k < 3; k++) begin
      total++; if (req_ready[3] !== 1'b1) begin bad++; $display("FAIL zc_ready[%0d] got=%0b want=1", k, req_ready[3]); end
      step();
      total++; if (q_valid_in !== 1'b0) begin bad++; $display("FAIL zc_valid[%0d] got=%0b want=0", k, q_valid_in); end
      total++; if (drop_cnt !== 16'(k + 1)) begin bad++; $display("FAIL zc_drop[%0d] got=%0d want=%0d", k, drop_cnt, k + 1); end
    end
    req_valid = '0;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL zc_not_held got=%b want=1111", req_ready); end
  endtask

  task automatic test_flush();
    q_full = 1'b1; q_empty = 1'b0;
    req_valid = 4'b0101;
    set_lane(0, IL'(50), CW'(1));
    set_lane(2, IL'(52), CW'(1));
    step();
    req_valid = '0;
    total++; if (req_ready !== 4'b1010) begin bad++; $display("FAIL fl_pre_ready got=%b want=1010", req_ready); end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0; q_full = 1'b0;
    #1;
    total++; if (flush_state !== 2'd1 || req_ready !== 4'b0000) begin bad++; $display("FAIL fl_drain got=%0d/%b want=1/0000", flush_state, req_ready); end
    total++; if (q_valid_in !== 1'b1 || grant_id !== 2'd2 || q_item_in !== IL'(52)) begin bad++; $display("FAIL fl_grant_a got=%0b/%0d/%0d want=1/2/52", q_valid_in, grant_id, q_item_in); end
    step();
    total++; if (q_valid_in !== 1'b1 || grant_id !== 2'd0 || q_item_in !== IL'(50)) begin bad++; $display("FAIL fl_grant_b got=%0b/%0d/%0d want=1/0/50", q_valid_in, grant_id, q_item_in); end
    step();
    total++; if (q_valid_in !== 1'b0 || flush_state !== 2'd2) begin bad++; $display("FAIL fl_wait got=%0b/%0d want=0/2", q_valid_in, flush_state); end
    for (int k = 0; k < 6; k++) begin
      total++; if (flush_done !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL fl_waiting[%0d] got=%0b/%b want=0/0000", k, flush_done, req_ready); end
      step();
    end
    q_empty = 1'b1;
    step();
    total++; if (flush_done !== 1'b1 || flush_state !== 2'd3 || req_ready !== 4'b0000) begin bad++; $display("FAIL fl_done got=%0b/%0d/%b want=1/3/0000", flush_done, flush_state, req_ready); end
    step();
    total++; if (flush_done !== 1'b0 || flush_state !== 2'd0) begin bad++; $display("FAIL fl_pulse_end got=%0b/%0d want=0/0", flush_done, flush_state); end
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL fl_resume got=%b want=1111", req_ready); end
  endtask

  task automatic test_reset_mid_flush();
    q_full = 1'b1; q_empty = 1'b0;
    req_valid = 4'b0010;
    set_lane(1, IL'(61), CW'(4));
    step();
    req_valid = '0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    total++; if (flush_state !== 2'd1) begin bad++; $display("FAIL rmf_drain got=%0d want=1", flush_state); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; q_full = 1'b0; q_empty = 1'b1;
    #1;
    total++; if (flush_state !== 2'd0 || q_valid_in !== 1'b0) begin bad++; $display("FAIL rmf_abort got=%0d/%0b want=0/0", flush_state, q_valid_in); end
    total++; if (req_ready !== 4'b1111 || drop_cnt !== 16'd0) begin bad++; $display("FAIL rmf_clean got=%b/%0d want=1111/0", req_ready, drop_cnt); end
  endtask

  task automatic test_fairness_soak();
    int gcnt[N];
    longint issued_sum;
    longint queue_sum;
    int accepted;
    int granted;
    int gmax;
    int gmin;
    issued_sum = 0; queue_sum = 0; accepted = 0; granted = 0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    q_full = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      if (q_valid_in === 1'b1) begin
        queue_sum += q_counter_in;
        gcnt[grant_id]++;
        granted++;
      end
      for (int i = 0; i < N; i++) begin
        set_lane(i, IL'($urandom), CW'($urandom_range(1, 2047)));
        if (req_ready[i]) begin
          issued_sum += req_counter[i*CW +: CW];
          accepted++;
        end
      end
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      if (q_valid_in === 1'b1) begin
        queue_sum += q_counter_in;
        gcnt[grant_id]++;
        granted++;
      end
      step();
    end
    gmax = gcnt[0]; gmin = gcnt[0];
    for (int i = 1; i < N; i++) begin
      if (gcnt[i] > gmax) gmax = gcnt[i];
      if (gcnt[i] < gmin) gmin = gcnt[i];
    end
    total++; if (gmax - gmin > 1) begin bad++; $display("FAIL soak_fair got=%0d..%0d want spread<=1", gmin, gmax); end
    total++; if (queue_sum !== issued_sum) begin bad++; $display("FAIL soak_sum got=%0d want=%0d", queue_sum, issued_sum); end
    total++; if (granted !== accepted) begin bad++; $display("FAIL soak_count got=%0d want=%0d", granted, accepted); end
    total++; if (granted < 390) begin bad++; $display("FAIL soak_throughput got=%0d want>=390", granted); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_zero_counter();
    test_flush();
    test_reset_mid_flush();
    test_fairness_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
